ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage, directly downstream of the PC unit.
- Latches the current PC and issues one read per instruction over a valid/ready instruction-memory interface.
- Captures the returned word and presents {inst, inst_pc} to the decode stage with a valid/ready handshake.
- Pulses pc_wen so the PC unit's register advances only after decode accepts the instruction.

Parameters:
- CPU_WIDTH, 32, datapath/address width.
- TIMEOUT_CYCLES, 255, max cycles waiting for arready/rvalid before fatal timeout; counter width $clog2(TIMEOUT_CYCLES+1).
- NOP_INST, 32'h00000013, instruction substituted on fault.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- pc  in  CPU_WIDTH  current PC from the PC unit.
- pc_wen  out  1  one-cycle pulse; PC register loads pc_next on this edge.
- araddr  out  CPU_WIDTH  read address.
- arvalid  out  1  read request valid.
- arready  in  1  memory accepts address.
- rdata  in  32  read data.
- rresp  in  2  response; 0 = OKAY, nonzero = error.
- rvalid  in  1  read data valid.
- rready  out  1  IFU accepts data.
- inst  out  32  fetched instruction.
- inst_pc  out  CPU_WIDTH  PC of inst.
- inst_valid  out  1  inst/inst_pc valid to decode.
- inst_ready  in  1  decode accepts.
- fetch_err  out  2  00 none, 01 bus error, 10 timeout, 11 misaligned.

Behaviour:
- Reset (async, active-high): state=IDLE; arvalid=rready=inst_valid=pc_wen=0; araddr=inst_pc=0; inst=NOP_INST; fetch_err=00; timeout counter=0.
- States: IDLE, AR, R, OUT, HALT.
- IDLE:
  - Latch pc into araddr and inst_pc.
  - Clear fetch_err to 00.
  - Go to AR next cycle, unconditionally. First request after reset therefore appears 1 cycle after rst deasserts.
- AR:
  - arvalid=1 with araddr held stable.
  - On arvalid&arready: go to R and clear the counter.
  - arvalid must not drop before the handshake completes.
- R:
  - rready=1.
  - On rvalid: inst=rdata; go to OUT.
  - If rresp!=0 in the same cycle: inst=NOP_INST, fetch_err=01.
- OUT:
  - inst_valid=1; inst, inst_pc and fetch_err held stable.
  - On inst_valid&inst_ready: pc_wen=1 for exactly that cycle; go to IDLE.
  - Next IDLE cycle samples the updated pc. Minimum fetch period is 4 cycles with zero-wait memory.
- Timeout:
  - Counter increments each cycle in AR or R without the respective handshake.
  - When it reaches TIMEOUT_CYCLES, go to HALT.
- HALT:
  - arvalid=rready=inst_valid=pc_wen=0; fetch_err=10 held.
  - Exit only via rst. Late responses are ignored.
- Handshake in the same cycle the counter hits TIMEOUT_CYCLES: the handshake wins, no timeout.
- rst asserted mid-transaction: immediate return to reset values. The memory side must tolerate a dropped request.
- pc_wen is never asserted outside the OUT handshake cycle, including error fetches. The PC advances past a faulting instruction; trap handling is downstream's responsibility.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE, if pc[1:0]!=0, skip AR/R and go directly to OUT.
  - Present inst=NOP_INST, inst_pc=pc, fetch_err=11.
  - No memory request is issued.
- Undefined:
  - No check; araddr[1:0] is forced to 00.
  - fetch_err never takes value 11.

Decomposition:
- Shared defines/package: CPU_WIDTH, NOP_INST, fetch_err codes (FERR_NONE/BUS/TIMEOUT/MISALIGN), FSM state encoding.
- One natural sub-module, ifu_timeout_cnt: counter with clear/enable and a hit output compared against TIMEOUT_CYCLES.
- All other logic stays in ifu_fetch.

Test Plan:
- Zero-wait memory, pc=0x80000000, rdata=0x00100093, inst_ready=1 -> arvalid in cycle 1 after reset; inst_valid with inst=0x00100093, inst_pc=0x80000000 in cycle 3; pc_wen pulse in the same cycle; next araddr=0x80000004.
- arready delayed 3 cycles and rvalid delayed 5 cycles -> araddr stable and arvalid held throughout; exactly one pc_wen per instruction; no early inst_valid.
- inst_ready held low for 10 cycles in OUT -> inst/inst_pc stable, pc_wen=0 for all 10 cycles, then exactly one pulse when inst_ready=1.
- rvalid with rresp=2'b10 -> inst=0x00000013, fetch_err=01, pc_wen pulses on accept; next fetch shows fetch_err=00.
- arready never asserted, TIMEOUT_CYCLES=8 -> HALT after 8 wait cycles, fetch_err=10, arvalid=0; a late rvalid is ignored; rst recovers to IDLE.
- With IFU_MISALIGN_CHECK_EN, pc=0x80000002 -> no arvalid; OUT with fetch_err=11, inst=NOP. Without the macro -> araddr=0x80000000.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared constants and encodings for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int          CPU_WIDTH = 32;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef enum logic [1:0] {
    FERR_NONE     = 2'b00,
    FERR_BUS      = 2'b01,
    FERR_TIMEOUT  = 2'b10,
    FERR_MISALIGN = 2'b11
  } ferr_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_OUT,
    S_HALT
  } state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage signal bundle: PC unit, instruction memory and decode handshakes.
interface ifu_fetch_if #(
  parameter int CPU_WIDTH = ifu_fetch_pkg::CPU_WIDTH
);
  logic [CPU_WIDTH-1:0] pc;
  logic                 pc_wen;
  logic [CPU_WIDTH-1:0] araddr;
  logic                 arvalid;
  logic                 arready;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;
  logic [31:0]          inst;
  logic [CPU_WIDTH-1:0] inst_pc;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [1:0]           fetch_err;

  // Fetch unit side.
  modport master (
    input  pc, arready, rdata, rresp, rvalid, inst_ready,
    output pc_wen, araddr, arvalid, rready, inst, inst_pc, inst_valid, fetch_err
  );

  // Environment side: PC unit, memory and decode.
  modport slave (
    output pc, arready, rdata, rresp, rvalid, inst_ready,
    input  pc_wen, araddr, arvalid, rready, inst, inst_pc, inst_valid, fetch_err
  );
endinterface

// File: rtl/ifu_timeout_cnt.sv
// Wait-cycle counter for the fetch stage; hit flags that one more wait cycle
// brings the count to TIMEOUT_CYCLES.
module ifu_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int            W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + W'(1);
  end

  // Independent of en so the FSM's next-state logic has no comb loop through it.
  assign hit = (count == LAST);
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one memory read per instruction, handed to decode.
// Optional macro IFU_MISALIGN_CHECK_EN reports misaligned PCs instead of fetching.
module ifu_fetch #(
  parameter int          CPU_WIDTH      = ifu_fetch_pkg::CPU_WIDTH,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INST       = ifu_fetch_pkg::NOP_INST
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);
  import ifu_fetch_pkg::*;

  state_e               state_q, state_d;
  logic [CPU_WIDTH-1:0] araddr_q, araddr_d;
  logic [CPU_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]          inst_q, inst_d;
  ferr_e                ferr_q, ferr_d;
  logic                 cnt_clr, cnt_en, cnt_hit;

  ifu_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .hit (cnt_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      araddr_q  <= '0;
      inst_pc_q <= '0;
      inst_q    <= NOP_INST;
      ferr_q    <= FERR_NONE;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    state_d        = state_q;
    araddr_d       = araddr_q;
    inst_pc_d      = inst_pc_q;
    inst_d         = inst_q;
    ferr_d         = ferr_q;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    bus.arvalid    = 1'b0;
    bus.rready     = 1'b0;
    bus.inst_valid = 1'b0;
    bus.pc_wen     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_clr   = 1'b1;
        ferr_d    = FERR_NONE;
        inst_pc_d = bus.pc;
`ifdef IFU_MISALIGN_CHECK_EN
        araddr_d = bus.pc;
        if (bus.pc[1:0] != 2'b00) begin
          inst_d  = NOP_INST;
          ferr_d  = FERR_MISALIGN;
          state_d = S_OUT;
        end else begin
          state_d = S_AR;
        end
`else
        araddr_d = {bus.pc[CPU_WIDTH-1:2], 2'b00};
        state_d  = S_AR;
`endif
      end

      S_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) begin
          cnt_clr = 1'b1;
          state_d = S_R;
        end else begin
          cnt_en = 1'b1;
          if (cnt_hit) begin
            ferr_d  = FERR_TIMEOUT;
            state_d = S_HALT;
          end
        end
      end

      S_R: begin
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          state_d = S_OUT;
          if (bus.rresp != 2'b00) begin
            inst_d = NOP_INST;
            ferr_d = FERR_BUS;
          end else begin
            inst_d = bus.rdata;
          end
        end else begin
          cnt_en = 1'b1;
          if (cnt_hit) begin
            ferr_d  = FERR_TIMEOUT;
            state_d = S_HALT;
          end
        end
      end

      S_OUT: begin
        bus.inst_valid = 1'b1;
        if (bus.inst_ready) begin
          bus.pc_wen = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_HALT: ;  // only rst leaves this state

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.araddr    = araddr_q;
  assign bus.inst_pc   = inst_pc_q;
  assign bus.inst      = inst_q;
  assign bus.fetch_err = ferr_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vectors, corner sequences and
// randomized fetches against a transaction-level reference model.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam int TMO = 8;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] model_pc;

  ifu_fetch_if #(.CPU_WIDTH(32)) bus ();

  ifu_fetch #(.CPU_WIDTH(32), .TIMEOUT_CYCLES(TMO), .NOP_INST(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ar_wait;
    int          r_wait;
    int          d_wait;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] exp_inst;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Acts as memory, decode and PC unit for one instruction. Entered and left
  // at a falling edge while the DUT is in IDLE.
  task automatic fetch_one(input int ar_wait, input int r_wait, input int d_wait,
                           input logic [31:0] data, input logic [1:0] resp,
                           input logic [31:0] exp_inst, input logic [1:0] exp_err);
    logic [31:0] exp_addr;
    exp_addr = {model_pc[31:2], 2'b00};
    check("idle_arvalid", 32'(bus.arvalid), 32'd0);
    check("idle_inst_valid", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    for (int i = 0; i <= ar_wait; i++) begin
      check("ar_arvalid", 32'(bus.arvalid), 32'd1);
      check("ar_araddr", bus.araddr, exp_addr);
      check("ar_no_inst_valid", 32'(bus.inst_valid), 32'd0);
      bus.arready = (i == ar_wait);
      @(negedge clk);
    end
    bus.arready = 1'b0;
    for (int i = 0; i <= r_wait; i++) begin
      check("r_rready", 32'(bus.rready), 32'd1);
      check("r_arvalid_low", 32'(bus.arvalid), 32'd0);
      check("r_no_inst_valid", 32'(bus.inst_valid), 32'd0);
      bus.rvalid = (i == r_wait);
      bus.rdata  = (i == r_wait) ? data : $urandom;
      bus.rresp  = (i == r_wait) ? resp : 2'($urandom);
      @(negedge clk);
    end
    bus.rvalid = 1'b0;
    for (int i = 0; i <= d_wait; i++) begin
      check("out_inst_valid", 32'(bus.inst_valid), 32'd1);
      check("out_inst", bus.inst, exp_inst);
      check("out_inst_pc", bus.inst_pc, model_pc);
      check("out_fetch_err", 32'(bus.fetch_err), 32'(exp_err));
      bus.inst_ready = (i == d_wait);
      #1;
      check("out_pc_wen", 32'(bus.pc_wen), 32'(i == d_wait));
      @(negedge clk);
    end
    bus.inst_ready = 1'b0;
    model_pc = model_pc + 32'd4;
    bus.pc   = model_pc;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b0;
    bus.rdata      = '0;
    bus.rresp      = '0;
    bus.inst_ready = 1'b0;
    #1;
    check("rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("rst_rready", 32'(bus.rready), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_araddr", bus.araddr, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_inst", bus.inst, NOP_INST);
    check("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_pc_wen", 32'(bus.pc_wen), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] d;
    logic [1:0]  r;

    vecs[0] = '{0, 0, 0,  32'h0010_0093, 2'b00, 32'h0010_0093, 2'b00};
    vecs[1] = '{3, 5, 0,  32'h0020_8133, 2'b00, 32'h0020_8133, 2'b00};
    vecs[2] = '{0, 0, 10, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[3] = '{0, 0, 0,  32'h1234_5678, 2'b10, 32'h0000_0013, 2'b01};
    vecs[4] = '{0, 0, 0,  32'h0000_0517, 2'b00, 32'h0000_0517, 2'b00};
    vecs[5] = '{7, 7, 1,  32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 2'b00};
    vecs[6] = '{2, 1, 2,  32'h0BAD_0BAD, 2'b01, 32'h0000_0013, 2'b01};

    model_pc = 32'h8000_0000;
    bus.pc   = model_pc;
    @(negedge clk);
    do_reset();

    foreach (vecs[k])
      fetch_one(vecs[k].ar_wait, vecs[k].r_wait, vecs[k].d_wait, vecs[k].data,
                vecs[k].resp, vecs[k].exp_inst, vecs[k].exp_err);

    // Randomized fetches; expectations follow the bus-response rules directly.
    for (int k = 0; k < 40; k++) begin
      d = $urandom;
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetch_one($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4), d, r,
                (r != 2'b00) ? NOP_INST : d, (r != 2'b00) ? 2'b01 : 2'b00);
    end

    // Misaligned PC.
    model_pc = 32'h8000_0002;
    bus.pc   = model_pc;
`ifdef IFU_MISALIGN_CHECK_EN
    @(negedge clk);
    check("mis_arvalid", 32'(bus.arvalid), 32'd0);
    check("mis_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("mis_inst", bus.inst, NOP_INST);
    check("mis_inst_pc", bus.inst_pc, 32'h8000_0002);
    check("mis_fetch_err", 32'(bus.fetch_err), 32'd3);
    bus.inst_ready = 1'b1;
    #1;
    check("mis_pc_wen", 32'(bus.pc_wen), 32'd1);
    @(negedge clk);
    bus.inst_ready = 1'b0;
`else
    fetch_one(0, 0, 0, 32'h0000_0093, 2'b00, 32'h0000_0093, 2'b00);
`endif
    model_pc = 32'h8000_0100;
    bus.pc   = model_pc;

    // Reset in the middle of a fetch drops everything at once.
    @(negedge clk);
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check("mid_rready_before", 32'(bus.rready), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rready", 32'(bus.rready), 32'd0);
    check("mid_inst_pc", bus.inst_pc, 32'd0);
    check("mid_araddr", bus.araddr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch_one(1, 2, 0, 32'h0040_0113, 2'b00, 32'h0040_0113, 2'b00);

    // Address never accepted: timeout into HALT after TMO wait cycles.
    n = 0;
    @(negedge clk);
    while (bus.arvalid && n < 5 * TMO) begin
      n++;
      @(negedge clk);
    end
    check("tmo_wait_cycles", 32'(n), 32'(TMO));
    check("tmo_fetch_err", 32'(bus.fetch_err), 32'd2);
    check("tmo_arvalid", 32'(bus.arvalid), 32'd0);
    bus.rvalid     = 1'b1;
    bus.rdata      = 32'h1111_1111;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_rready", 32'(bus.rready), 32'd0);
      check("halt_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("halt_pc_wen", 32'(bus.pc_wen), 32'd0);
      check("halt_fetch_err", 32'(bus.fetch_err), 32'd2);
      check("halt_arvalid", 32'(bus.arvalid), 32'd0);
    end

    do_reset();
    fetch_one(0, 0, 0, 32'h0000_0073, 2'b00, 32'h0000_0073, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
